mem_store_buffer: RTL

//   MEM-stage initiator for DataMemo: accepts load/store requests from the pipeline and drives MemRd/MemWr_final/Address/Data_in.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/store_buf_cam.sv | 50 +++++
 rtl/mem_store_buffer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the MEM-stage store buffer.
//   SB_DEPTH    default number of store-buffer entries
//   SB_AW/SB_DW default address/data widths of a buffered store
//   sb_state_t  buffer operating mode: normal run or draining for a fence
//   sb_entry_t  one buffered store at default widths
package pipeline_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;

  typedef enum logic [0:0] {
    SB_RUN   = 1'b0,
    SB_FLUSH = 1'b1
  } sb_state_t;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buf_cam.sv
// Address CAM over the store-buffer entries.
//   ent_valid   per-entry valid bits
//   ent_addr    per-entry word addresses
//   lookup_addr address of the load being matched (full-width compare)
//   wr_ptr      next write slot; the entry just below it is the youngest
//   hit_idx     index of the youngest matching entry
//   hit         at least one valid entry matches
// wr_ptr/hit_idx exist only when STORE_FORWARD_EN is defined, since only
// forwarding needs to know which entry matched.
module store_buf_cam #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ent_valid,
  input  logic [AW-1:0]    ent_addr [DEPTH],
  input  logic [AW-1:0]    lookup_addr,
`ifdef STORE_FORWARD_EN
  input  logic [PW-1:0]    wr_ptr,
  output logic [PW-1:0]    hit_idx,
`endif
  output logic             hit
);

  logic [DEPTH-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_vec[i] = ent_valid[i] && (ent_addr[i] == lookup_addr);
    end
  end

  assign hit = |hit_vec;

`ifdef STORE_FORWARD_EN
  // Walk from oldest (wr_ptr) to youngest (wr_ptr-1); the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit_idx = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PW'(k);
      if (hit_vec[idx]) begin
        hit_idx = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage initiator for DataMemo with a posted-store FIFO.
// Stores are queued and drained in program order; miss loads own the memory
// port ahead of draining. flush_req drains the buffer as a fence.
// Optional macro: STORE_FORWARD_EN (load hits are served from the youngest
// matching entry instead of stalling until the match has drained).
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_write           MEM op present / 1=store 0=load
//   req_addr/req_wdata            op word address / store data
//   flush_req                     level fence request
//   Stall_MEM                     request not accepted this cycle
//   load_data                     load result, same cycle as acceptance
//   flush_done                    buffer empty during an active fence
//   MemRd/MemWr_final             DataMemo read / write enable
//   Address/Data_in               DataMemo address / write data
//   Data_out                      DataMemo combinational read data
//   sb_count                      occupied entries
module mem_store_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_wdata,
  input  logic                   flush_req,
  output logic                   Stall_MEM,
  output logic [DW-1:0]          load_data,
  output logic                   flush_done,
  output logic                   MemRd,
  output logic                   MemWr_final,
  output logic [AW-1:0]          Address,
  output logic [DW-1:0]          Data_in,
  input  logic [DW-1:0]          Data_out,
  output logic [$clog2(DEPTH):0] sb_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_state_t        state_q, state_d;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];

  logic             hit;
`ifdef STORE_FORWARD_EN
  logic [PW-1:0]    hit_idx;
`endif

  logic in_run, is_load, is_store, load_miss;
  logic empty, full, do_drain, do_enq;

  store_buf_cam #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_cam (
    .ent_valid   (ent_valid),
    .ent_addr    (ent_addr),
    .lookup_addr (req_addr),
`ifdef STORE_FORWARD_EN
    .wr_ptr      (wr_ptr),
    .hit_idx     (hit_idx),
`endif
    .hit         (hit)
  );

  assign in_run    = (state_q == SB_RUN);
  assign is_load   = req_valid && !req_write && in_run;
  assign is_store  = req_valid &&  req_write && in_run;
  assign load_miss = is_load && !hit;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  // Head drains whenever a miss-load is not using the port.
  assign do_drain  = !empty && !load_miss;
  assign do_enq    = is_store && (!full || do_drain);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SB_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_RUN:   if (flush_req)  state_d = SB_FLUSH;
      SB_FLUSH: if (!flush_req) state_d = SB_RUN;
      default:  state_d = SB_RUN;
    endcase
  end

  // Drain clears the head before enqueue sets the tail so a same-slot
  // enqueue on a full buffer leaves the new entry valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (do_drain) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      if (do_enq) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= req_addr;
        ent_data[wr_ptr]  <= req_wdata;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      case ({do_enq, do_drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, including the
  // input-driven combinational paths.
  always_comb begin
    Stall_MEM   = 1'b0;
    load_data   = '0;
    flush_done  = 1'b0;
    MemRd       = 1'b0;
    MemWr_final = 1'b0;
    Address     = '0;
    Data_in     = '0;
    if (reset_n) begin
      if (req_valid) begin
        if (!in_run) begin
          Stall_MEM = 1'b1;
        end else if (req_write) begin
          Stall_MEM = !do_enq;
        end else if (hit) begin
`ifdef STORE_FORWARD_EN
          load_data = ent_data[hit_idx];
`else
          Stall_MEM = 1'b1;
`endif
        end else begin
          load_data = Data_out;
        end
      end
      if (load_miss) begin
        MemRd   = 1'b1;
        Address = req_addr;
      end else if (do_drain) begin
        MemWr_final = 1'b1;
        Address     = ent_addr[rd_ptr];
        Data_in     = ent_data[rd_ptr];
      end
      flush_done = (state_q == SB_FLUSH) && empty && flush_req;
    end
  end

  assign sb_count = count;

endmodule
